ts_switch_sequencer: RTL and testbench

TS_SWITCH_SEQUENCER -- requirements
Module: ts_switch_sequencer

---
 rtl/ts_ctrl_pkg.sv | 22 ++
 rtl/seq_timer.sv | 26 ++
 rtl/ts_switch_sequencer.sv | 129 ++++++++++++
 tb/tb_ts_switch_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_ctrl_pkg.sv
// Shared TS-control definitions: sequencer state encoding, channel ids, packet length.
package ts_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_ARMED  = 2'd2,
    ST_HOLD   = 2'd3
  } seq_state_e;

  localparam logic [1:0] CH1 = 2'd0;
  localparam logic [1:0] CH2 = 2'd1;
  localparam logic [1:0] CH3 = 2'd2;
  localparam logic [1:0] CH4 = 2'd3;

  localparam int unsigned TS_PKT_LEN = 188;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Shared 16-bit cycle counter: clear has priority over count; tc_o flags cnt == limit_i.
module seq_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [15:0] limit_i,
  output logic        tc_o
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = 16'd0;
    else if (en_i) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= 16'd0;
    else      cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == limit_i);

endmodule

// File: rtl/ts_switch_sequencer.sv
// TS input mux sequencer: defers channel switches to the target's packet boundary,
// forcing the switch on timeout and enforcing a holdoff after every switch.
module ts_switch_sequencer
  import ts_ctrl_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'd2048,
  parameter logic [7:0]  HOLDOFF = 8'(TS_PKT_LEN)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_channel,
  input  logic       req_en,
  input  logic [3:0] sop,
  input  logic [3:0] valid,
  output logic [1:0] sel,
  output logic       sel_en,
  output logic       switching,
  output logic       switch_done,
  output logic       timeout_err,
  output logic       abort,
  output logic [7:0] switch_count
);

  seq_state_e state_q, state_d;
  logic [1:0] sel_q, sel_d, target_q, target_d;
  logic       sel_en_q, sel_en_d, switching_q;
  logic       done_q, done_d, tmo_q, tmo_d, abort_q, abort_d;
  logic [7:0] count_q, count_d;
  logic       retarget, tmr_clr, tmr_en, tmr_tc;
  logic [15:0] tmr_limit;

  assign tmr_limit = (state_q == ST_HOLD) ? ({8'd0, HOLDOFF} - 16'd1) : (TIMEOUT - 16'd1);
  assign tmr_en    = (state_q == ST_ARMED) || (state_q == ST_HOLD);

  seq_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .limit_i (tmr_limit),
    .tc_o    (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    sel_en_d = sel_en_q;
    target_d = target_q;
    count_d  = count_q;
    done_d   = 1'b0;
    tmo_d    = 1'b0;
    abort_d  = 1'b0;
    retarget = 1'b0;
    if (!req_en) begin
      state_d  = ST_IDLE;
      sel_en_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_ARMED;
          target_d = req_channel;
        end
        ST_LOCKED: begin
          if (req_channel != sel_q) begin
            state_d  = ST_ARMED;
            target_d = req_channel;
          end
        end
        ST_ARMED: begin
          if (!valid[target_q]) begin
            abort_d = 1'b1;
            state_d = sel_en_q ? ST_LOCKED : ST_IDLE;
          end else if (sop[target_q] || tmr_tc) begin
            state_d  = ST_HOLD;
            sel_d    = target_q;
            sel_en_d = 1'b1;
            done_d   = 1'b1;
            tmo_d    = !sop[target_q];
            count_d  = sat_inc8(count_q);
          end else if ((req_channel != target_q) && (req_channel != sel_q)) begin
            target_d = req_channel;
            retarget = 1'b1;
          end else if ((req_channel == sel_q) && sel_en_q) begin
            state_d = ST_LOCKED;
          end
        end
        ST_HOLD: begin
          if (tmr_tc) state_d = ST_LOCKED;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // The counter restarts on every state entry and on each retarget.
    tmr_clr = retarget || (state_d != state_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= CH1;
      sel_en_q    <= 1'b0;
      target_q    <= CH1;
      switching_q <= 1'b0;
      done_q      <= 1'b0;
      tmo_q       <= 1'b0;
      abort_q     <= 1'b0;
      count_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      sel_en_q    <= sel_en_d;
      target_q    <= target_d;
      switching_q <= (state_d == ST_ARMED);
      done_q      <= done_d;
      tmo_q       <= tmo_d;
      abort_q     <= abort_d;
      count_q     <= count_d;
    end
  end

  assign sel          = sel_q;
  assign sel_en       = sel_en_q;
  assign switching    = switching_q;
  assign switch_done  = done_q;
  assign timeout_err  = tmo_q;
  assign abort        = abort_q;
  assign switch_count = count_q;

endmodule

// File: tb/tb_ts_switch_sequencer.sv
// Bench for ts_switch_sequencer: default-parameter instance for directed timing cases,
// short-parameter instance for the vector table, saturation and randomized model comparison.
module tb_ts_switch_sequencer;

  localparam int S_TIMEOUT = 8;
  localparam int S_HOLDOFF = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req_channel = 2'd0;
  logic       req_en = 1'b0;
  logic [3:0] sop = 4'd0;
  logic [3:0] valid = 4'd0;

  logic [1:0] sel, sel_s;
  logic       sel_en, switching, switch_done, timeout_err, abort;
  logic       sel_en_s, switching_s, switch_done_s, timeout_err_s, abort_s;
  logic [7:0] switch_count, switch_count_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ts_switch_sequencer dut (
    .clk(clk), .rst(rst), .req_channel(req_channel), .req_en(req_en), .sop(sop), .valid(valid),
    .sel(sel), .sel_en(sel_en), .switching(switching), .switch_done(switch_done),
    .timeout_err(timeout_err), .abort(abort), .switch_count(switch_count)
  );

  ts_switch_sequencer #(.TIMEOUT(16'(S_TIMEOUT)), .HOLDOFF(8'(S_HOLDOFF))) dut_s (
    .clk(clk), .rst(rst), .req_channel(req_channel), .req_en(req_en), .sop(sop), .valid(valid),
    .sel(sel_s), .sel_en(sel_en_s), .switching(switching_s), .switch_done(switch_done_s),
    .timeout_err(timeout_err_s), .abort(abort_s), .switch_count(switch_count_s)
  );

  // Output bundle: {sel, sel_en, switching, switch_done, timeout_err, abort, switch_count}
  function automatic logic [14:0] pack(input logic [1:0] s, input logic e, input logic sw,
                                       input logic d, input logic t, input logic a,
                                       input logic [7:0] c);
    return {s, e, sw, d, t, a, c};
  endfunction

  function automatic logic [14:0] outs_main();
    return pack(sel, sel_en, switching, switch_done, timeout_err, abort, switch_count);
  endfunction

  function automatic logic [14:0] outs_small();
    return pack(sel_s, sel_en_s, switching_s, switch_done_s, timeout_err_s, abort_s, switch_count_s);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_en = 1'b0; req_channel = 2'd0; sop = 4'd0; valid = 4'd0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  // ---------------- behavioural reference (short-parameter instance) ----------------
  localparam int M_IDLE = 0, M_LOCKED = 1, M_ARMED = 2, M_HOLD = 3;
  int         m_mode, m_waited, m_hold_left, m_tgt, m_sel, m_cnt;
  logic       m_en, m_done, m_tmo, m_abort;

  task automatic model_reset();
    m_mode = M_IDLE; m_waited = 0; m_hold_left = 0; m_tgt = 0; m_sel = 0; m_cnt = 0;
    m_en = 0; m_done = 0; m_tmo = 0; m_abort = 0;
  endtask

  task automatic model_step();
    m_done = 0; m_tmo = 0; m_abort = 0;
    if (!req_en) begin
      m_mode = M_IDLE; m_en = 0;
    end else if (m_mode == M_IDLE) begin
      m_mode = M_ARMED; m_tgt = int'(req_channel); m_waited = 0;
    end else if (m_mode == M_LOCKED) begin
      if (int'(req_channel) != m_sel) begin
        m_mode = M_ARMED; m_tgt = int'(req_channel); m_waited = 0;
      end
    end else if (m_mode == M_ARMED) begin
      if (!valid[m_tgt]) begin
        m_abort = 1; m_mode = m_en ? M_LOCKED : M_IDLE;
      end else if (sop[m_tgt] || (m_waited + 1 == S_TIMEOUT)) begin
        m_tmo = !sop[m_tgt];
        m_done = 1; m_sel = m_tgt; m_en = 1;
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        m_mode = M_HOLD; m_hold_left = S_HOLDOFF;
      end else if (int'(req_channel) != m_tgt && int'(req_channel) != m_sel) begin
        m_tgt = int'(req_channel); m_waited = 0;
      end else if (int'(req_channel) == m_sel && m_en) begin
        m_mode = M_LOCKED;
      end else begin
        m_waited++;
      end
    end else begin
      m_hold_left--;
      if (m_hold_left == 0) m_mode = M_LOCKED;
    end
  endtask

  function automatic logic [14:0] outs_model();
    return pack(2'(m_sel), m_en, (m_mode == M_ARMED), m_done, m_tmo, m_abort, 8'(m_cnt));
  endfunction

  // ---------------- vector table (short-parameter instance) ----------------
  typedef struct {
    logic       en;
    logic [1:0] ch;
    logic [3:0] sp;
    logic [3:0] vl;
    logic [14:0] exp;
  } vec_t;

  vec_t tbl[22];

  task automatic tv(input int i, input logic en, input logic [1:0] ch, input logic [3:0] sp,
                    input logic [3:0] vl, input logic [1:0] s, input logic e, input logic sw,
                    input logic d, input logic t, input logic a, input logic [7:0] c);
    tbl[i].en = en; tbl[i].ch = ch; tbl[i].sp = sp; tbl[i].vl = vl;
    tbl[i].exp = pack(s, e, sw, d, t, a, c);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    bit bad;
    int waited;
    logic [7:0] prev_cnt;

    // IDLE->ARMED, sop commit, 4-cycle hold, rearm, abort, retarget, cancel, timeout, disable
    tv(0,  1, 2'd2, 4'h0, 4'hF, 2'd0, 0, 1, 0, 0, 0, 8'd0);
    tv(1,  1, 2'd2, 4'h4, 4'hF, 2'd2, 1, 0, 1, 0, 0, 8'd1);
    tv(2,  1, 2'd1, 4'h0, 4'hF, 2'd2, 1, 0, 0, 0, 0, 8'd1);
    tv(3,  1, 2'd1, 4'h0, 4'hF, 2'd2, 1, 0, 0, 0, 0, 8'd1);
    tv(4,  1, 2'd1, 4'h0, 4'hF, 2'd2, 1, 0, 0, 0, 0, 8'd1);
    tv(5,  1, 2'd1, 4'h0, 4'hF, 2'd2, 1, 0, 0, 0, 0, 8'd1);
    tv(6,  1, 2'd1, 4'h0, 4'hF, 2'd2, 1, 1, 0, 0, 0, 8'd1);
    tv(7,  1, 2'd1, 4'h0, 4'hD, 2'd2, 1, 0, 0, 0, 1, 8'd1);
    tv(8,  1, 2'd1, 4'h0, 4'hF, 2'd2, 1, 1, 0, 0, 0, 8'd1);
    tv(9,  1, 2'd3, 4'h0, 4'hF, 2'd2, 1, 1, 0, 0, 0, 8'd1);
    tv(10, 1, 2'd2, 4'h0, 4'hF, 2'd2, 1, 0, 0, 0, 0, 8'd1);
    tv(11, 1, 2'd3, 4'h0, 4'hF, 2'd2, 1, 1, 0, 0, 0, 8'd1);
    for (int i = 12; i <= 18; i++) tv(i, 1, 2'd3, 4'h0, 4'hF, 2'd2, 1, 1, 0, 0, 0, 8'd1);
    tv(19, 1, 2'd3, 4'h0, 4'hF, 2'd3, 1, 0, 1, 1, 0, 8'd2);
    tv(20, 0, 2'd3, 4'h0, 4'hF, 2'd3, 0, 0, 0, 0, 0, 8'd2);
    tv(21, 0, 2'd3, 4'h0, 4'hF, 2'd3, 0, 0, 0, 0, 0, 8'd2);

    // ---- reset values ----
    do_reset();
    rst = 1'b0;
    #1;
    chk("reset_main", 32'(outs_main()), 32'(pack(2'd0, 0, 0, 0, 0, 0, 8'd0)));
    chk("reset_small", 32'(outs_small()), 32'(pack(2'd0, 0, 0, 0, 0, 0, 8'd0)));
    rst = 1'b1;

    // ---- table ----
    for (int i = 0; i < 22; i++) begin
      req_en = tbl[i].en; req_channel = tbl[i].ch; sop = tbl[i].sp; valid = tbl[i].vl;
      tick();
      chk($sformatf("table_row%0d", i), 32'(outs_small()), 32'(tbl[i].exp));
    end

    // ---- sop commit at cycle 10 (default parameters) ----
    do_reset();
    req_en = 1; req_channel = 2'd2; valid = 4'hF;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 1) chk("armed_after_enable", 32'(switching), 32'd1);
    end
    chk("no_commit_before_sop", 32'(switch_done), 32'd0);
    sop = 4'h4;
    tick();
    sop = 4'h0;
    chk("sop_commit_c10", 32'(outs_main()), 32'(pack(2'd2, 1, 0, 1, 0, 0, 8'd1)));

    // ---- holdoff: request after 5 cycles, no arming for 188 cycles ----
    bad = 0;
    for (int k = 1; k <= 188; k++) begin
      if (k == 6) req_channel = 2'd1;
      tick();
      if (switching !== 1'b0 || switch_done !== 1'b0) bad = 1;
    end
    chk("holdoff_quiet_188", 32'(bad), 32'd0);
    tick();
    chk("armed_after_holdoff", 32'(switching), 32'd1);
    sop = 4'h2;
    tick();
    sop = 4'h0;
    chk("commit_after_holdoff", 32'(outs_main()), 32'(pack(2'd1, 1, 0, 1, 0, 0, 8'd2)));

    // ---- timeout: no sop on target, forced switch on 2048th armed cycle ----
    repeat (188) tick();
    req_channel = 2'd3;
    tick();
    chk("armed_for_timeout", 32'(switching), 32'd1);
    bad = 0;
    for (int k = 1; k <= 2047; k++) begin
      tick();
      if (k < 2047 && (switch_done !== 1'b0 || switching !== 1'b1)) bad = 1;
    end
    chk("no_early_timeout", 32'(bad), 32'd0);
    chk("no_commit_at_2047", 32'(switch_done), 32'd0);
    tick();
    chk("timeout_commit_2048", 32'(outs_main()), 32'(pack(2'd3, 1, 0, 1, 1, 0, 8'd3)));

    // ---- abort: target loses valid, sel kept, back to LOCKED ----
    repeat (188) tick();
    req_channel = 2'd1;
    tick();
    chk("armed_for_abort", 32'(switching), 32'd1);
    valid = 4'hD;
    tick();
    valid = 4'hF;
    chk("abort_pulse", 32'(outs_main()), 32'(pack(2'd3, 1, 0, 0, 0, 1, 8'd3)));
    tick();
    chk("rearm_from_locked", 32'(outs_main()), 32'(pack(2'd3, 1, 1, 0, 0, 0, 8'd3)));

    // ---- disable while armed, then reset mid-switch ----
    req_en = 0;
    tick();
    chk("disable_while_armed", 32'(outs_main()), 32'(pack(2'd3, 0, 0, 0, 0, 0, 8'd3)));
    req_en = 1;
    tick();
    chk("armed_from_idle", 32'(switching), 32'd1);
    sop = 4'h2;
    #2;
    rst = 1'b0;
    #1;
    chk("reset_mid_armed", 32'(outs_main()), 32'(pack(2'd0, 0, 0, 0, 0, 0, 8'd0)));
    tick();
    sop = 4'h0; req_en = 0;
    rst = 1'b1;
    tick();
    chk("no_done_after_reset", 32'(outs_main()), 32'(pack(2'd0, 0, 0, 0, 0, 0, 8'd0)));

    // ---- 300 forced switches saturate the counter ----
    do_reset();
    req_en = 1; valid = 4'hF;
    bad = 0;
    prev_cnt = 8'd0;
    for (int i = 0; i < 300; i++) begin
      req_channel = (i % 2 == 0) ? 2'd1 : 2'd2;
      seen = 0;
      waited = 0;
      while (!seen && waited < 50) begin
        tick();
        waited++;
        if (switch_done_s) seen = 1;
      end
      if (!seen || !timeout_err_s || switch_count_s < prev_cnt) bad = 1;
      prev_cnt = switch_count_s;
    end
    chk("forced_switch_sequence", 32'(bad), 32'd0);
    chk("count_saturated", 32'(switch_count_s), 32'hFF);

    // ---- randomized run against the reference model ----
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      req_en = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 11) == 0) req_channel = 2'($urandom_range(0, 3));
      for (int b = 0; b < 4; b++) sop[b] = ($urandom_range(0, 7) == 0);
      valid = 4'hF;
      if ($urandom_range(0, 24) == 0) valid[$urandom_range(0, 3)] = 1'b0;
      model_step();
      tick();
      chk($sformatf("random_cycle%0d", n), 32'(outs_small()), 32'(outs_model()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
